// File: rtl/riscv_pkg.sv
// Shared RV64 fetch-path constants and the fetch buffer entry layout.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 64'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instruction}, flushable.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch: issues sequential requests, buffers
// returned words with their pc, and drops stale responses after redirects.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;

  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [PW-1:0]   tag_wr;
  logic [PW-1:0]   tag_rd;

  logic            req_fire;
  logic            keep;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Credits cover buffered and outstanding words so a push never overflows.
  assign imem_req_valid = reset & ~redirect & ~full
                        & ((count + inflight) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign keep = imem_rsp_valid & ~redirect & (drop == '0);
  assign push_entry = '{pc: tag_mem[tag_rd], inst: imem_rsp_data};

  assign inst_valid = ~redirect & ~empty;
  assign pop        = inst_valid & inst_ready;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      if (redirect)      fetch_pc <= redirect_pc;
      else if (req_fire) fetch_pc <= fetch_pc + PC_INC;

      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);

      // Every word still outstanding at a redirect is stale.
      if (redirect)
        drop <= inflight - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && (drop != '0))
        drop <= drop - CW'(1);

      if (req_fire)       tag_wr <= tag_wr + PW'(1);
      if (imem_rsp_valid) tag_rd <= tag_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a queue-based model.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        out_q[$];
  ent_t        buf_q[$];
  logic [63:0] mpc;
  logic [63:0] seen[$];
  int          cyc;
  int          issued;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    out_q.delete();
    buf_q.delete();
    mpc = RPC;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc += 3;
  endtask

  // One clock: drive inputs, check outputs, advance the model.
  task automatic step(input logic r, input logic [63:0] rpc,
                      input logic rdy, input logic ir, input int lat);
    logic rsp;
    logic ereq;
    logic eiv;
    req_t e;
    int   due;
    @(negedge clk);
    rsp = (out_q.size() > 0) && (out_q[0].due <= cyc);
    redirect       = r;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    inst_ready     = ir;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? out_q[0].data : $urandom;
    ereq = !r && ((buf_q.size() + out_q.size()) < DEPTH);
    eiv  = !r && (buf_q.size() > 0);
    #1;
    chk("req_valid", 64'(imem_req_valid), 64'(ereq));
    if (ereq) chk("req_addr", imem_req_addr, mpc);
    chk("inst_valid", 64'(inst_valid), 64'(eiv));
    if (eiv) begin
      chk("inst_pc", inst_pc, buf_q[0].pc);
      chk("inst_data", 64'(inst_data), 64'(buf_q[0].data));
    end
    if (imem_req_valid && rdy) issued++;
    if (eiv && ir) begin
      seen.push_back(inst_pc);
      void'(buf_q.pop_front());
    end
    if (rsp) begin
      e = out_q.pop_front();
      if (!r && !e.stale) buf_q.push_back('{pc: e.addr, data: e.data});
    end
    if (r) begin
      buf_q.delete();
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      mpc = rpc;
    end else if (ereq && rdy) begin
      due = cyc + lat;
      if (out_q.size() > 0 && out_q[$].due > due) due = out_q[$].due;
      out_q.push_back('{addr: mpc, data: $urandom, due: due, stale: 1'b0});
      mpc = mpc + 64'd4;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    logic [63:0] rp;
    cyc = 0; issued = 0; vectors = 0; miscompares = 0;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; inst_ready = 1'b0;
    mpc = RPC;

    // Streaming with a 1-cycle memory.
    do_reset();
    seen.delete();
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1);
    chk("stream_cnt", 64'(seen.size()), 64'd6);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) chk("stream_pc", seen[i], 64'(4 * i));

    // Decode stalled: credits run out after DEPTH requests.
    do_reset();
    issued = 0;
    repeat (8) step(1'b0, '0, 1'b1, 1'b0, 1);
    chk("stall_issued", 64'(issued), 64'd4);

    // Two in flight, redirect drops both.
    do_reset();
    step(1'b1, 64'h10, 1'b1, 1'b1, 3);
    repeat (2) step(1'b0, '0, 1'b1, 1'b1, 3);
    step(1'b1, 64'h100, 1'b1, 1'b1, 3);
    seen.delete();
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1);
    if (seen.size() > 0) chk("redir_first_pc", seen[0], 64'h100);
    else chk("redir_first_pc_seen", 64'(seen.size()), 64'd1);

    // Response lands in the redirect cycle.
    do_reset();
    step(1'b1, 64'h40, 1'b1, 1'b1, 2);
    repeat (2) step(1'b0, '0, 1'b1, 1'b1, 2);
    step(1'b1, 64'h200, 1'b1, 1'b1, 2);
    seen.delete();
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1);
    if (seen.size() > 0) chk("redir_rsp_pc", seen[0], 64'h200);
    else chk("redir_rsp_seen", 64'(seen.size()), 64'd1);

    // Push and pop together at count=DEPTH-1, across pointer wrap.
    do_reset();
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1);
    seen.delete();
    repeat (12) step(1'b0, '0, 1'b1, 1'b1, 1);
    for (int i = 1; i < seen.size(); i++)
      chk("wrap_order", seen[i], seen[i-1] + 64'd4);

    // Reset with three words buffered.
    do_reset();
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1);
    chk("pre_rst_level", 64'(buf_q.size()), 64'd3);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) do_reset();
      rp = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF8;
      step($urandom_range(15) == 0, rp, $urandom_range(3) != 0,
           $urandom_range(3) != 0, $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
